// File: rtl/atm_session_ctrl.sv
// ATM card-session sequencer: language, PIN with retry/retention, operation menu,
// bounded withdraw/deposit/inquiry, and write-back of committed balances.
module atm_session_ctrl #(
   parameter int unsigned BAL_W         = 20,
   parameter int unsigned MAX_PIN_TRIES = 3,
   parameter int unsigned TIMEOUT_CYC   = 1000,
   parameter int unsigned WD_LIMIT      = 5000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             card_in,
   input  logic [BAL_W-1:0] acct_rd_data,
   input  logic             lang_valid,
   input  logic             lang_sel,
   input  logic             pin_valid,
   input  logic             pin_ok,
   input  logic             op_valid,
   input  logic [1:0]       op_sel,
   input  logic [BAL_W-1:0] amount,
   input  logic             another_valid,
   input  logic             another_yes,
   output logic             language,
   output logic [BAL_W-1:0] balance,
   output logic             acct_wr_en,
   output logic [BAL_W-1:0] acct_wr_data,
   output logic             op_done,
   output logic             error,
   output logic [2:0]       err_code,
   output logic             card_eject,
   output logic             card_retain,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LANG, S_PIN, S_MENU, S_EXEC, S_ANOTHER, S_EJECT, S_RETAIN
   } state_t;

   localparam int unsigned    TW      = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]     TRY_MAX = 4'(MAX_PIN_TRIES);
   localparam logic [BAL_W:0] WD_LIM  = (BAL_W+1)'(WD_LIMIT);

   localparam logic [2:0] ERR_NONE = 3'd0, ERR_PIN = 3'd1, ERR_FUNDS = 3'd2,
                          ERR_LIMIT = 3'd3, ERR_OVF = 3'd4, ERR_TIMEOUT = 3'd5,
                          ERR_RETAIN = 3'd6;

   state_t           state, state_d;
   logic [TW-1:0]    timer, timer_d;
   logic [3:0]       tries, tries_d;
   logic [BAL_W-1:0] withdrawn, wd_d;
   logic [1:0]       op_q, op_d;
   logic [BAL_W-1:0] amt_q, amt_d;
   logic             lang_d, wr_en_d, done_d, err_d, eject_d, retain_d, busy_d;
   logic [BAL_W-1:0] bal_d, wr_data_d;
   logic [2:0]       err_code_d;
   logic             wait_st, taken;

   logic [BAL_W:0]   wd_sum, dep_sum;
   logic [BAL_W-1:0] bal_sub;
   logic [3:0]       tries_inc;
   logic [TW-1:0]    timer_inc;
   logic             expired;

   assign wd_sum    = {1'b0, withdrawn} + {1'b0, amt_q};
   assign dep_sum   = {1'b0, balance} + {1'b0, amt_q};
   assign bal_sub   = balance - amt_q;
   assign tries_inc = tries + 4'd1;
   assign timer_inc = timer + TW'(1);
   assign expired   = (timer == T_LAST);
   assign wait_st   = state inside {S_LANG, S_PIN, S_MENU, S_ANOTHER};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         timer        <= '0;
         tries        <= '0;
         withdrawn    <= '0;
         op_q         <= '0;
         amt_q        <= '0;
         language     <= 1'b0;
         balance      <= '0;
         acct_wr_en   <= 1'b0;
         acct_wr_data <= '0;
         op_done      <= 1'b0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
         card_eject   <= 1'b0;
         card_retain  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_d;
         timer        <= timer_d;
         tries        <= tries_d;
         withdrawn    <= wd_d;
         op_q         <= op_d;
         amt_q        <= amt_d;
         language     <= lang_d;
         balance      <= bal_d;
         acct_wr_en   <= wr_en_d;
         acct_wr_data <= wr_data_d;
         op_done      <= done_d;
         error        <= err_d;
         err_code     <= err_code_d;
         card_eject   <= eject_d;
         card_retain  <= retain_d;
         busy         <= busy_d;
      end
   end

   always_comb begin
      state_d    = state;
      timer_d    = timer;
      tries_d    = tries;
      wd_d       = withdrawn;
      op_d       = op_q;
      amt_d      = amt_q;
      lang_d     = language;
      bal_d      = balance;
      wr_data_d  = acct_wr_data;
      err_code_d = err_code;
      wr_en_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      taken      = 1'b0;

      // Card removal mid-session wins over everything, including a pending EXEC result.
      if (!card_in && (wait_st || state == S_EXEC)) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (card_in) begin
                  state_d    = S_LANG;
                  bal_d      = acct_rd_data;
                  err_code_d = ERR_NONE;
                  tries_d    = '0;
                  wd_d       = '0;
                  timer_d    = '0;
               end
            end
            S_LANG: begin
               if (lang_valid) begin
                  taken   = 1'b1;
                  lang_d  = lang_sel;
                  state_d = S_PIN;
               end
            end
            S_PIN: begin
               if (pin_valid) begin
                  taken = 1'b1;
                  if (pin_ok) begin
                     state_d = S_MENU;
                     tries_d = '0;
                  end else begin
                     err_d   = 1'b1;
                     tries_d = tries_inc;
                     if (tries_inc >= TRY_MAX) begin
                        state_d    = S_RETAIN;
                        err_code_d = ERR_RETAIN;
                     end else begin
                        err_code_d = ERR_PIN;
                     end
                  end
               end
            end
            S_MENU: begin
               if (op_valid) begin
                  taken   = 1'b1;
                  op_d    = op_sel;
                  amt_d   = amount;
                  state_d = (op_sel == 2'b11) ? S_EJECT : S_EXEC;
               end
            end
            S_EXEC: begin
               state_d = S_ANOTHER;
               timer_d = '0;
               case (op_q)
                  2'b00: begin
                     if (amt_q > balance) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FUNDS;
                     end else if (wd_sum > WD_LIM) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LIMIT;
                     end else begin
                        bal_d     = bal_sub;
                        wd_d      = wd_sum[BAL_W-1:0];
                        wr_en_d   = 1'b1;
                        wr_data_d = bal_sub;
                        done_d    = 1'b1;
                     end
                  end
                  2'b01: begin
                     if (dep_sum[BAL_W]) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVF;
                     end else begin
                        bal_d     = dep_sum[BAL_W-1:0];
                        wr_en_d   = 1'b1;
                        wr_data_d = dep_sum[BAL_W-1:0];
                        done_d    = 1'b1;
                     end
                  end
                  2'b10:   done_d = 1'b1;
                  default: ;
               endcase
            end
            S_ANOTHER: begin
               if (another_valid) begin
                  taken   = 1'b1;
                  state_d = another_yes ? S_MENU : S_EJECT;
               end
            end
            S_EJECT, S_RETAIN: begin
               if (!card_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         // Shared inactivity timer: an accepted strobe reloads it, and a strobe
         // arriving in the expiry cycle suppresses the timeout.
         if (wait_st) begin
            if (taken) begin
               timer_d = '0;
            end else if (expired) begin
               state_d    = S_EJECT;
               err_d      = 1'b1;
               err_code_d = ERR_TIMEOUT;
            end else begin
               timer_d = timer_inc;
            end
         end
      end

      busy_d   = (state_d != S_IDLE);
      eject_d  = (state_d == S_EJECT);
      retain_d = (state_d == S_RETAIN);
   end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised next-generation ATM session controller. Sequences one card session: card detect, language, PIN with configurable retry limit and card retention, operation menu, withdraw/deposit/inquiry with bounds checking, and "another service". Owns an internal inactivity timer and a per-session withdrawal limit. Writes committed balances back to the account store through a one-cycle write strobe.

Parameters:
BAL_W, 20, balance/amount width in bits
MAX_PIN_TRIES, 3, wrong PINs allowed before the card is retained (1..15)
TIMEOUT_CYC, 1000, idle cycles allowed in any wait state before timeout (>=2)
WD_LIMIT, 5000, maximum total withdrawn per session (< 2^BAL_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
card_in  in  1  card present in slot (level)
acct_rd_data  in  BAL_W  account balance from store, valid while card_in=1
lang_valid  in  1  language choice strobe
lang_sel  in  1  1=Arabic, 0=English
pin_valid  in  1  PIN check result strobe
pin_ok  in  1  PIN correct, qualified by pin_valid
op_valid  in  1  operation request strobe
op_sel  in  2  00 withdraw, 01 deposit, 10 inquiry, 11 end session
amount  in  BAL_W  operation amount, sampled with op_valid
another_valid  in  1  another-service answer strobe
another_yes  in  1  1=continue, qualified by another_valid
language  out  1  latched language
balance  out  BAL_W  working session balance
acct_wr_en  out  1  one-cycle write strobe to account store
acct_wr_data  out  BAL_W  balance to write, valid with acct_wr_en
op_done  out  1  one-cycle pulse on successful operation
error  out  1  one-cycle pulse on any error
err_code  out  3  last error: 0 none, 1 bad PIN, 2 insufficient funds, 3 over session limit, 4 deposit overflow, 5 timeout, 6 card retained
card_eject  out  1  eject request, held in EJECT state
card_retain  out  1  retain request, held in RETAIN state
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; pin-try counter, session withdrawn total, timer cleared. All outputs registered.
- States: IDLE, LANG, PIN, MENU, EXEC, ANOTHER, EJECT, RETAIN.
- IDLE: card_in=1 -> LANG next cycle; balance <= acct_rd_data; err_code <= 0; try counter and withdrawn total cleared.
- LANG: lang_valid -> latch language, -> PIN.
- PIN: pin_valid&pin_ok -> MENU, try counter cleared. pin_valid&!pin_ok -> error pulse, err_code=1, counter+1; if counter reaches MAX_PIN_TRIES -> RETAIN (err_code=6), else remain in PIN.
- MENU: op_valid latches op_sel/amount -> EXEC; op_sel=11 -> EJECT directly, no EXEC.
- EXEC (exactly one cycle, checks in this priority):
  - withdraw: amount>balance -> err 2; withdrawn+amount>WD_LIMIT -> err 3; else balance-=amount, withdrawn+=amount.
  - deposit: balance+amount computed in BAL_W+1 bits; carry set -> err 4; else balance+=amount.
  - inquiry: no change, success.
  - success: op_done pulse; acct_wr_en pulse with new balance (deposit/withdraw only), same cycle as op_done. Error: error pulse, no write, balance unchanged.
  - always -> ANOTHER next cycle.
- ANOTHER: another_valid&another_yes -> MENU; another_valid&!another_yes -> EJECT.
- Timer: reloads to 0 on entry to every wait state (LANG, PIN, MENU, ANOTHER) and on every accepted strobe; increments otherwise; reaching TIMEOUT_CYC-1 -> EJECT with error pulse, err_code=5. Strobe in the same cycle as expiry wins (no timeout).
- EJECT: card_eject=1 until card_in=0, then IDLE. RETAIN: card_retain=1 until card_in=0, then IDLE. Timer inactive in both.
- Card removed (card_in=0) in LANG/PIN/MENU/ANOTHER/EXEC: -> IDLE next cycle, no write, any EXEC result discarded, no op_done; balance held.
- Strobes not belonging to the current state are ignored. err_code holds until next error or next card insertion.
- Async reset mid-session: immediate return to IDLE, no pending write issued.

Test Plan:
- Insert card, acct_rd_data=1000, English, PIN ok, withdraw 300, another=no -> acct_wr_data=700 with op_done, card_eject until card_in=0, IDLE.
- Withdraw 1200 with balance 1000 -> error, err_code=2, no acct_wr_en, balance 1000, state ANOTHER; then withdraw 4000 then 2000 with balance 9000 -> second gives err_code=3.
- Deposit 1 with balance 2^20-1 -> err_code=4, balance unchanged; deposit 500 with balance 100 -> write 600.
- Three wrong PINs (MAX_PIN_TRIES=3) -> error pulses with err_code=1,1 then card_retain with err_code=6; two wrong then ok -> MENU.
- No strobe in MENU for TIMEOUT_CYC cycles -> EJECT, err_code=5; op_valid at cycle TIMEOUT_CYC-1 -> accepted, no timeout.
- Pull card during EXEC of a 100 withdraw -> IDLE, no acct_wr_en, no op_done; assert rst mid-PIN -> all outputs 0 immediately.
